// File: rtl/decode_stage_packer.sv
// IF/ID pipeline register for RV32I: packs the decode word, builds the immediate, counts squash/stall cycles.
// Define DEC_ILLEGAL_CHK_EN to add the illegal-opcode check and the sticky D_illegal flag.
module decode_stage_packer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      F_inst,
  input  logic [XLEN-1:0]  F_pc,
  input  logic             stall,
  input  logic             next_pc_sel,
  output logic [23:0]      D_out,
  output logic [31:0]      D_inst,
  output logic [XLEN-1:0]  D_pc,
  output logic [XLEN-1:0]  D_imm,
  output logic             D_valid,
  output logic [CNT_W-1:0] squash_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             D_illegal
);

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [23:0] BUBBLE = 24'h00_0004;

  typedef enum logic [4:0] {
    OP_LOAD   = 5'b00000,
    OP_OPIMM  = 5'b00100,
    OP_AUIPC  = 5'b00101,
    OP_STORE  = 5'b01000,
    OP_OP     = 5'b01100,
    OP_LUI    = 5'b01101,
    OP_BRANCH = 5'b11000,
    OP_JALR   = 5'b11001,
    OP_JAL    = 5'b11011
  } opcode_e;

  typedef struct packed {
    logic       inst30;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] opcode;
  } dec_word_t;

  dec_word_t   fields;
  logic        illegal;
  logic [31:0] imm32;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      D_inst     <= NOP;
      D_pc       <= '0;
      D_valid    <= 1'b0;
      squash_cnt <= '0;
      stall_cnt  <= '0;
    end else if (!next_pc_sel) begin
      D_inst  <= NOP;
      D_pc    <= F_pc;
      D_valid <= 1'b0;
      if (squash_cnt != '1) squash_cnt <= squash_cnt + 1'b1;
    end else if (stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end else begin
      D_inst  <= F_inst;
      D_pc    <= F_pc;
      D_valid <= 1'b1;
    end
  end

`ifdef DEC_ILLEGAL_CHK_EN
  logic known_op;
  logic illegal_q;

  always_comb begin
    known_op = 1'b0;
    case (D_inst[6:2])
      OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: known_op = 1'b1;
      default:                            known_op = 1'b0;
    endcase
    illegal = D_valid && ((D_inst[1:0] != 2'b11) || !known_op);
  end

  // Sticky until reset: latches any illegal instruction that reached D.
  always_ff @(posedge clk) begin
    if (rst)          illegal_q <= 1'b0;
    else if (illegal) illegal_q <= 1'b1;
  end

  assign D_illegal = illegal_q;
`else
  assign illegal   = 1'b0;
  assign D_illegal = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    fields = '{inst30: D_inst[30], rs2: D_inst[24:20], rs1: D_inst[19:15],
               funct3: D_inst[14:12], rd: D_inst[11:7], opcode: D_inst[6:2]};
    D_out  = fields;
    // Redirect squashes in the same cycle so the Controller never latches a wrong-path op into E.
    if (!next_pc_sel || !D_valid || illegal) D_out = BUBBLE;
  end

  always_comb begin
    imm32 = '0;
    case (D_inst[6:2])
      OP_LOAD, OP_OPIMM, OP_JALR:
        imm32 = {{20{D_inst[31]}}, D_inst[31:20]};
      OP_STORE:
        imm32 = {{20{D_inst[31]}}, D_inst[31:25], D_inst[11:7]};
      OP_BRANCH:
        imm32 = {{19{D_inst[31]}}, D_inst[31], D_inst[7], D_inst[30:25], D_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {D_inst[31:12], 12'h000};
      OP_JAL:
        imm32 = {{11{D_inst[31]}}, D_inst[31], D_inst[19:12], D_inst[20], D_inst[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
    if (illegal) imm32 = '0;
  end

  assign D_imm = XLEN'($signed(imm32));

endmodule

// File: tb/tb_decode_stage_packer.sv
// Self-checking bench for decode_stage_packer: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a field-level reference model; a CNT_W=4 copy checks saturation.
module tb_decode_stage_packer;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef DEC_ILLEGAL_CHK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_inst, f_pc;
  logic        stall, next_pc_sel;

  logic [23:0] d_out,   s_d_out;
  logic [31:0] d_inst,  s_d_inst, d_pc, s_d_pc, d_imm, s_d_imm;
  logic        d_valid, s_d_valid, d_illegal, s_d_illegal;
  logic [15:0] squash_cnt, stall_cnt;
  logic [3:0]  s_squash_cnt, s_stall_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_inst, m_pc;
  logic        m_valid, m_ill;
  int          m_sq, m_st, m_sq4, m_st4;

  always #5 clk = ~clk;

  decode_stage_packer #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .F_inst(f_inst), .F_pc(f_pc), .stall(stall),
    .next_pc_sel(next_pc_sel), .D_out(d_out), .D_inst(d_inst), .D_pc(d_pc),
    .D_imm(d_imm), .D_valid(d_valid), .squash_cnt(squash_cnt),
    .stall_cnt(stall_cnt), .D_illegal(d_illegal)
  );

  decode_stage_packer #(.XLEN(32), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .F_inst(f_inst), .F_pc(f_pc), .stall(stall),
    .next_pc_sel(next_pc_sel), .D_out(s_d_out), .D_inst(s_d_inst), .D_pc(s_d_pc),
    .D_imm(s_d_imm), .D_valid(s_d_valid), .squash_cnt(s_squash_cnt),
    .stall_cnt(s_stall_cnt), .D_illegal(s_d_illegal)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit is_illegal(input logic [31:0] i);
    int op = int'(i[6:2]);
    return (i[1:0] != 2'b11) || !(op inside {0, 4, 5, 8, 12, 13, 24, 25, 27});
  endfunction

  function automatic logic [23:0] exp_pack(input logic [31:0] i, input logic valid, input logic npc);
    if (!npc || !valid) return 24'h000004;
    if (ILL_EN && is_illegal(i)) return 24'h000004;
    return {i[30], i[24:20], i[19:15], i[14:12], i[11:7], i[6:2]};
  endfunction

  // Immediate rebuilt from its numeric definition: field weights, then two's-complement wrap.
  function automatic logic [31:0] exp_imm(input logic [31:0] i, input logic valid);
    int v;
    int op = int'(i[6:2]);
    if (ILL_EN && valid && is_illegal(i)) return 32'h0;
    case (op)
      0, 4, 25: begin
        v = int'(i[31:20]);
        if (v >= 2048) v -= 4096;
      end
      8: begin
        v = int'(i[31:25]) * 32 + int'(i[11:7]);
        if (v >= 2048) v -= 4096;
      end
      24: begin
        v = int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      5, 13: v = int'(i & 32'hFFFF_F000);
      27: begin
        v = int'(i[31]) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic st, input logic nps);
    f_inst = inst; f_pc = pc; stall = st; next_pc_sel = nps;
  endtask

  // One clock edge: reference model follows the same edge, outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_inst = NOP; m_pc = '0; m_valid = 1'b0; m_ill = 1'b0;
      m_sq = 0; m_st = 0; m_sq4 = 0; m_st4 = 0;
    end else begin
      if (ILL_EN && m_valid && is_illegal(m_inst)) m_ill = 1'b1;
      if (!next_pc_sel) begin
        m_inst = NOP; m_pc = f_pc; m_valid = 1'b0;
        m_sq = sat(m_sq + 1, 65535); m_sq4 = sat(m_sq4 + 1, 15);
      end else if (stall) begin
        m_st = sat(m_st + 1, 65535); m_st4 = sat(m_st4 + 1, 15);
      end else begin
        m_inst = f_inst; m_pc = f_pc; m_valid = 1'b1;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".D_out"},   32'(d_out),   32'(exp_pack(m_inst, m_valid, next_pc_sel)));
    check({tag, ".D_inst"},  d_inst,       m_inst);
    check({tag, ".D_pc"},    d_pc,         m_pc);
    check({tag, ".D_valid"}, 32'(d_valid), 32'(m_valid));
    if (next_pc_sel) check({tag, ".D_imm"}, d_imm, exp_imm(m_inst, m_valid));
    check({tag, ".squash_cnt"},   32'(squash_cnt),   m_sq);
    check({tag, ".stall_cnt"},    32'(stall_cnt),    m_st);
    check({tag, ".s_squash_cnt"}, 32'(s_squash_cnt), m_sq4);
    check({tag, ".s_stall_cnt"},  32'(s_stall_cnt),  m_st4);
    check({tag, ".D_illegal"},    32'(d_illegal),    32'(m_ill));
    check({tag, ".s_D_illegal"},  32'(s_d_illegal),  32'(m_ill));
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [23:0] exp_out;
    logic [31:0] exp_imm;
  } vec_t;

  vec_t vecs[9];
  logic [4:0] legal_ops[9];

  initial begin
    vecs[0] = '{32'h00A2_8293, 24'h28A0A4, 32'h0000_000A};  // addi x5,x5,10
    vecs[1] = '{32'hFE00_08E3, 24'h800238, 32'hFFFF_FFF0};  // beq x0,x0,-16
    vecs[2] = '{32'h0061_2423, 24'h184908, 32'h0000_0008};  // sw x6,8(x2)
    vecs[3] = '{32'h1234_50B7, 24'h0D142D, 32'h1234_5000};  // lui x1,0x12345
    vecs[4] = '{32'hFFDF_F0EF, 24'hF7FC3B, 32'hFFFF_FFFC};  // jal x1,-4
    vecs[5] = '{32'h0020_81B3, 24'h08206C, 32'h0000_0000};  // add x3,x1,x2
    vecs[6] = '{32'h8000_0297, 24'h0000A5, 32'h8000_0000};  // auipc x5,0x80000
    vecs[7] = '{32'hFFF0_2383, 24'hFC08E0, 32'hFFFF_FFFF};  // lw x7,-1(x0)
    vecs[8] = '{32'h0000_8067, 24'h002019, 32'h0000_0000};  // jalr x0,0(x1)
    legal_ops = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                  5'b01101, 5'b11000, 5'b11001, 5'b11011};

    // Reset, then NOPs flow through
    rst = 1'b1;
    drive(NOP, 32'h0, 1'b0, 1'b1);
    tick();
    check_all("reset");
    check("reset.D_valid_zero", 32'(d_valid), 32'h0);
    check("reset.D_out_bubble", 32'(d_out), 32'h4);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(NOP, 32'h100 + 32'(4 * k), 1'b0, 1'b1);
      tick();
      check_all("nop");
    end
    check("nop.D_valid_one", 32'(d_valid), 32'h1);
    check("nop.D_out", 32'(d_out), 32'h4);
    check("nop.counters", 32'(squash_cnt) + 32'(stall_cnt), 32'h0);

    // Directed packing/immediate table
    foreach (vecs[k]) begin
      drive(vecs[k].inst, 32'h1000 + 32'(4 * k), 1'b0, 1'b1);
      tick();
      check($sformatf("tbl%0d.D_out", k), 32'(d_out), 32'(vecs[k].exp_out));
      check($sformatf("tbl%0d.D_imm", k), d_imm, vecs[k].exp_imm);
      check_all($sformatf("tbl%0d", k));
    end

    // Load a branch then hold it for two stall cycles
    drive(32'hFE00_08E3, 32'h2000, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(32'h00A2_8293, 32'h2004, 1'b1, 1'b1);
      tick();
      check_all("stall");
    end
    check("stall.D_inst_held", d_inst, 32'hFE00_08E3);
    check("stall.D_pc_held", d_pc, 32'h2000);
    check("stall.stall_cnt", 32'(stall_cnt), 32'd2);
    check("stall.D_imm", d_imm, 32'hFFFF_FFF0);

    // Redirect: D_out bubbles before the edge, D becomes a bubble after it
    drive(32'h0020_81B3, 32'h3000, 1'b0, 1'b0);
    #2;
    check("squash.same_cycle_D_out", 32'(d_out), 32'h4);
    check("squash.pre_edge_valid", 32'(d_valid), 32'h1);
    tick();
    check_all("squash");
    check("squash.D_valid", 32'(d_valid), 32'h0);
    check("squash.squash_cnt", 32'(squash_cnt), 32'd1);
    check("squash.D_pc", d_pc, 32'h3000);

    // Long stall: 4-bit counters must saturate, not wrap
    for (int k = 0; k < 20; k++) begin
      drive(32'h0061_2423, 32'h4000, 1'b1, 1'b1);
      tick();
    end
    check_all("sat");
    check("sat.s_stall_cnt", 32'(s_stall_cnt), 32'hF);
    check("sat.stall_cnt", 32'(stall_cnt), 32'd22);

    // Illegal opcode 0x7F
    drive(32'h0000_007F, 32'h5000, 1'b0, 1'b1);
    tick();
    check_all("illegal");
    check("illegal.D_out", 32'(d_out), ILL_EN ? 32'h4 : 32'h1F);
    for (int k = 0; k < 3; k++) begin
      drive(NOP, 32'h5004 + 32'(4 * k), 1'b0, 1'b1);
      tick();
      check_all("illegal_after");
    end
    check("illegal.sticky", 32'(d_illegal), ILL_EN ? 32'h1 : 32'h0);

    // Reset during a simultaneous stall+redirect overrides both
    rst = 1'b1;
    drive(32'h0000_007F, 32'h6000, 1'b1, 1'b0);
    tick();
    check_all("rst_mid");
    check("rst_mid.D_illegal", 32'(d_illegal), 32'h0);
    check("rst_mid.D_pc", d_pc, 32'h0);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 500; k++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 9) < 8) inst[6:0] = {legal_ops[$urandom_range(0, 8)], 2'b11};
      rst = ($urandom_range(0, 99) < 2);
      drive(inst, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) != 0));
      #2;
      if (!rst) check("rand.pre_edge_D_out", 32'(d_out), 32'(exp_pack(m_inst, m_valid, next_pc_sel)));
      tick();
      check_all("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
